rule_unpacker_512_32: RTL and testbench

Unpacks the 512-bit packed rule stream (16 lanes × 32 bits, each lane two 16-bit rule IDs) back into a 32-bit, one-lane-per-beat rule stream. It sits downstream of the non-fast-pattern matcher's 512-bit rule FIFO and feeds 32-bit rule consumers, such as the rule-check and reorder stages. It reverses the packing performed by the 32→512 rule packer and preserves packet framing (sop/eop).

---
 rtl/rule_unpacker_512_32_pkg.sv | 34 +++
 rtl/rule_unpacker_512_32_if.sv | 33 +++
 rtl/rule_unpacker_512_32_lane_pick16.sv | 23 ++
 rtl/rule_unpacker_512_32.sv | 129 ++++++++++++
 tb/tb_rule_unpacker_512_32.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rule_unpacker_512_32_pkg.sv
// Shared types and widths for the 512->32 rule unpacker.
// Optional build macro: RULE_UNPACKER_ZERO_SKIP_EN (drop all-zero lanes at load).
package rule_unpacker_512_32_pkg;

    localparam int unsigned IN_W    = 512;
    localparam int unsigned OUT_W   = 32;
    localparam int unsigned RULE_W  = 16;
    localparam int unsigned LANE_W  = 32;
    localparam int unsigned N_LANES = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned EMPTY_W = 6;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned MASK_W  = N_LANES + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic [RULE_W-1:0] rule_b;
        logic [RULE_W-1:0] rule_a;
    } lane_s;

    // Lanes carried by a beat: all 16, or 16 minus the empty-lane count on eop.
    // The empty-lane count is at most 15, so at least one lane always survives.
    function automatic logic [N_LANES-1:0] valid_mask(input logic       eop,
                                                      input logic [3:0] empty_lanes);
        logic [4:0] n;
        n = eop ? (5'(N_LANES) - 5'(empty_lanes)) : 5'(N_LANES);
        return N_LANES'((MASK_W'(1) << n) - MASK_W'(1));
    endfunction

endpackage

// File: rtl/rule_unpacker_512_32_if.sv
// Packed-in / lane-out rule stream bundle for the unpacker.
interface rule_unpacker_512_32_if;
    import rule_unpacker_512_32_pkg::*;

    logic [IN_W-1:0]    in_rule_data;
    logic               in_rule_valid;
    logic               in_rule_sop;
    logic               in_rule_eop;
    logic [EMPTY_W-1:0] in_rule_empty;
    logic               in_rule_ready;

    logic [OUT_W-1:0]   out_rule_data;
    logic               out_rule_valid;
    logic               out_rule_sop;
    logic               out_rule_eop;
    logic               out_rule_ready;

    // Unpacker side
    modport slave (
        input  in_rule_data, in_rule_valid, in_rule_sop, in_rule_eop, in_rule_empty,
        output in_rule_ready,
        output out_rule_data, out_rule_valid, out_rule_sop, out_rule_eop,
        input  out_rule_ready
    );

    // Upstream producer / downstream consumer side
    modport master (
        output in_rule_data, in_rule_valid, in_rule_sop, in_rule_eop, in_rule_empty,
        input  in_rule_ready,
        input  out_rule_data, out_rule_valid, out_rule_sop, out_rule_eop,
        output out_rule_ready
    );
endinterface

// File: rtl/rule_unpacker_512_32_lane_pick16.sv
// Priority encoder over the pending-lane mask: lowest set lane plus shape flags.
module rule_unpacker_512_32_lane_pick16
    import rule_unpacker_512_32_pkg::*;
(
    input  logic [N_LANES-1:0] i_pend,
    output logic [IDX_W-1:0]   o_idx_c,
    output logic               o_onehot_c,
    output logic               o_nonzero_c
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        o_idx_c = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (i_pend[i]) begin
                o_idx_c = IDX_W'(i);
            end
        end
        o_nonzero_c = (i_pend != '0);
        o_onehot_c  = o_nonzero_c && ((i_pend & (i_pend - N_LANES'(1))) == '0);
    end

endmodule

// File: rtl/rule_unpacker_512_32.sv
// Unpacks 16-lane 512-bit rule beats into one 32-bit lane per cycle, keeping sop/eop.
// Optional build macro: RULE_UNPACKER_ZERO_SKIP_EN.
module rule_unpacker_512_32
    import rule_unpacker_512_32_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    rule_unpacker_512_32_if.slave   bus,
    output logic [CNT_W-1:0]        pkt_cnt
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IN_W-1:0]     r_buf;
    logic [IN_W-1:0]     w_buf_nxt;
    logic [N_LANES-1:0]  r_pend;
    logic [N_LANES-1:0]  w_pend_nxt;
    logic                r_eop;
    logic                w_eop_nxt;
    logic                r_sop_pend;
    logic                w_sop_pend_nxt;
    logic [CNT_W-1:0]    r_pkt_cnt;
    logic [CNT_W-1:0]    w_pkt_cnt_nxt;

    logic [IDX_W-1:0]    w_idx;
    logic                w_onehot;
    logic                w_nonzero;
    logic [N_LANES-1:0]  w_load_mask;
    logic                w_out_valid;
    logic                w_in_fire;
    logic                w_out_fire;
    lane_s               w_lane;
    logic [1:0]          w_empty_unused;

    rule_unpacker_512_32_lane_pick16 u_pick (
        .i_pend      (r_pend),
        .o_idx_c     (w_idx),
        .o_onehot_c  (w_onehot),
        .o_nonzero_c (w_nonzero)
    );

    // Byte-granular empty below one lane has no meaning here.
    assign w_empty_unused = bus.in_rule_empty[1:0];

    // Output lane mux from the buffered beat; everything else is a register.
    assign w_out_valid        = (r_state == DRAIN);
    assign w_lane             = r_buf[{w_idx, 5'b0} +: LANE_W];
    assign bus.out_rule_valid = w_out_valid;
    assign bus.out_rule_data  = w_out_valid ? w_lane : '0;
    assign bus.out_rule_sop   = w_out_valid & r_sop_pend;
    assign bus.out_rule_eop   = w_out_valid & r_eop & w_onehot;
    assign pkt_cnt            = r_pkt_cnt;

    // Accept a new beat when empty, or when the last pending lane leaves this cycle.
    assign bus.in_rule_ready = !rst && (!w_nonzero || (w_onehot && bus.out_rule_ready));
    assign w_in_fire         = bus.in_rule_valid & bus.in_rule_ready;
    assign w_out_fire        = w_out_valid & bus.out_rule_ready;

    // Pending-lane mask for the incoming beat.
`ifdef RULE_UNPACKER_ZERO_SKIP_EN
    logic [N_LANES-1:0] w_top_lane;
    always_comb begin
        w_load_mask = valid_mask(bus.in_rule_eop, bus.in_rule_empty[5:2]);
        w_top_lane  = w_load_mask & ~(w_load_mask >> 1);
        for (int k = 0; k < N_LANES; k++) begin
            if (bus.in_rule_data[k*LANE_W +: LANE_W] == '0) begin
                w_load_mask[k] = 1'b0;
            end
        end
        // Keep the final lane of an eop beat even if zero so eop is delivered.
        if (bus.in_rule_eop) begin
            w_load_mask = w_load_mask | w_top_lane;
        end
    end
`else
    always_comb begin
        w_load_mask = valid_mask(bus.in_rule_eop, bus.in_rule_empty[5:2]);
    end
`endif

    // Next-state: drain the current lane, then load a new beat on top of it.
    always_comb begin
        w_state_nxt    = r_state;
        w_buf_nxt      = r_buf;
        w_pend_nxt     = r_pend;
        w_eop_nxt      = r_eop;
        w_sop_pend_nxt = r_sop_pend;
        w_pkt_cnt_nxt  = r_pkt_cnt;

        if (w_out_fire) begin
            w_pend_nxt     = r_pend & ~(N_LANES'(1) << w_idx);
            w_sop_pend_nxt = 1'b0;
            if (bus.out_rule_eop) begin
                w_pkt_cnt_nxt = r_pkt_cnt + CNT_W'(1);
            end
        end

        if (w_in_fire) begin
            w_buf_nxt  = bus.in_rule_data;
            w_pend_nxt = w_load_mask;
            w_eop_nxt  = bus.in_rule_eop;
            if (bus.in_rule_sop) begin
                w_sop_pend_nxt = 1'b1;
            end
        end

        w_state_nxt = (w_pend_nxt != '0) ? DRAIN : IDLE;
    end

    // State and buffer registers, synchronous reset discards any partial packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_pend     <= '0;
            r_eop      <= 1'b0;
            r_sop_pend <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf      <= w_buf_nxt;
            r_pend     <= w_pend_nxt;
            r_eop      <= w_eop_nxt;
            r_sop_pend <= w_sop_pend_nxt;
            r_pkt_cnt  <= w_pkt_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rule_unpacker_512_32.sv
// Scoreboard bench for rule_unpacker_512_32 with a lane-list reference model.
module tb_rule_unpacker_512_32;
    import rule_unpacker_512_32_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pkt_cnt;

    rule_unpacker_512_32_if bus();

    rule_unpacker_512_32 dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        last;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pkt = 0;
    bit          sop_carry = 0;
    int          lanes_seen = 0;
    int          ready_mode = 0;
    bit          expect_valid_next = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_sop;
    logic        prev_eop;
    int          rst_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list the lanes a beat should produce, in order.
    task automatic model_beat(input logic [511:0] d, input logic sop, input logic eop,
                              input logic [5:0] empty);
        int          n;
        int          pushed;
        bit          keep;
        logic [31:0] lane;
        exp_t        e;
        n = eop ? 16 - int'(empty[5:2]) : 16;
        if (n < 1) n = 1;
        if (sop) sop_carry = 1;
        pushed = 0;
        for (int k = 0; k < n; k++) begin
            lane = d[k*32 +: 32];
            keep = 1;
`ifdef RULE_UNPACKER_ZERO_SKIP_EN
            keep = (lane != 0) || (eop && k == n - 1);
`endif
            if (keep) begin
                e.data = lane;
                e.sop  = sop_carry;
                e.eop  = 1'b0;
                e.last = 1'b0;
                q.push_back(e);
                sop_carry = 0;
                pushed++;
            end
        end
        if (pushed > 0) begin
            q[q.size()-1].last = 1'b1;
            q[q.size()-1].eop  = eop;
        end
        expect_valid_next = (pushed > 0);
    endtask

    // Monitor: compare every accepted output lane against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_in_ready", 32'(bus.in_rule_ready), 32'(0));
            if (rst_cycles > 0) begin
                check("rst_valid", 32'(bus.out_rule_valid), 32'(0));
                check("rst_sop", 32'(bus.out_rule_sop), 32'(0));
                check("rst_eop", 32'(bus.out_rule_eop), 32'(0));
                check("rst_data", bus.out_rule_data, 32'(0));
                check("rst_pkt_cnt", pkt_cnt, 32'(0));
            end
            rst_cycles++;
            q.delete();
            exp_pkt = 0;
            sop_carry = 0;
            prev_stall = 0;
            expect_valid_next = 0;
        end else begin
            if (rst_cycles > 0) begin
                check("post_rst_in_ready", 32'(bus.in_rule_ready), 32'(1));
                check("post_rst_valid", 32'(bus.out_rule_valid), 32'(0));
            end
            rst_cycles = 0;
            check("pkt_cnt", pkt_cnt, exp_pkt);
            if (expect_valid_next) begin
                check("latency_valid", 32'(bus.out_rule_valid), 32'(1));
                expect_valid_next = 0;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_rule_valid), 32'(1));
                check("stall_data", bus.out_rule_data, prev_data);
                check("stall_sop", 32'(bus.out_rule_sop), 32'(prev_sop));
                check("stall_eop", 32'(bus.out_rule_eop), 32'(prev_eop));
            end
            if (bus.out_rule_valid && bus.out_rule_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_lane: got data %0h expected no lane", bus.out_rule_data);
                end else begin
                    e = q.pop_front();
                    check("lane_data", bus.out_rule_data, e.data);
                    check("lane_sop", 32'(bus.out_rule_sop), 32'(e.sop));
                    check("lane_eop", 32'(bus.out_rule_eop), 32'(e.eop));
                    if (e.last) check("ready_on_last", 32'(bus.in_rule_ready), 32'(1));
                    if (e.eop) exp_pkt = exp_pkt + 1;
                    lanes_seen++;
                end
            end
            prev_stall = bus.out_rule_valid && !bus.out_rule_ready;
            prev_data  = bus.out_rule_data;
            prev_sop   = bus.out_rule_sop;
            prev_eop   = bus.out_rule_eop;
            if (bus.in_rule_valid && bus.in_rule_ready)
                model_beat(bus.in_rule_data, bus.in_rule_sop, bus.in_rule_eop, bus.in_rule_empty);
        end
    end

    // Downstream ready pattern.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_rule_ready = 1'b1;
            1:       bus.out_rule_ready = ~bus.out_rule_ready;
            default: bus.out_rule_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic send_beat(input logic [511:0] d, input logic sop, input logic eop,
                             input logic [5:0] empty);
        int t;
        bus.in_rule_data  = d;
        bus.in_rule_sop   = sop;
        bus.in_rule_eop   = eop;
        bus.in_rule_empty = empty;
        bus.in_rule_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.in_rule_ready) break;
            t++;
            if (t > 2000) begin
                $display("FAIL in_ready_timeout: got ready 0 expected 1");
                $fatal(1, "input stalled");
            end
        end
        @(posedge clk);
        #1;
        bus.in_rule_valid = 1'b0;
        bus.in_rule_sop   = 1'b0;
        bus.in_rule_eop   = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || bus.out_rule_valid) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (t >= 5000) begin
            errors++;
            $display("FAIL drain_timeout: got %0d lanes left expected 0", q.size());
        end
    endtask

    function automatic logic [31:0] rand_lane();
        if ($urandom_range(0, 3) == 0) return 32'h0;
        return $urandom | 32'h1;
    endfunction

    function automatic logic [511:0] rand_beat();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = rand_lane();
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d;
        int           base;
        int           nb;
        int           t;

        bus.in_rule_data   = '0;
        bus.in_rule_valid  = 1'b0;
        bus.in_rule_sop    = 1'b0;
        bus.in_rule_eop    = 1'b0;
        bus.in_rule_empty  = '0;
        bus.out_rule_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Two-lane single-beat packet.
        d = '0;
        d[31:0]  = 32'h0002_0001;
        d[63:32] = 32'h0004_0003;
        send_beat(d, 1'b1, 1'b1, 6'd56);
        wait_drain();
        check("pkt_cnt_after_first", pkt_cnt, 32'd1);

        // Full beat then a one-lane eop beat, back to back.
        d = '0;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'h1000_0000 + 32'(k);
        send_beat(d, 1'b1, 1'b0, 6'd0);
        d = '0;
        d[31:0] = 32'hABCD_0011;
        send_beat(d, 1'b0, 1'b1, 6'd60);
        wait_drain();

        // Alternating downstream ready.
        ready_mode = 1;
        d = '0;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'h2200_0000 + 32'(k * 3 + 1);
        send_beat(d, 1'b1, 1'b1, 6'd0);
        wait_drain();
        ready_mode = 0;

        // Sparse eop beat: only lanes 3 and 9 nonzero.
        d = '0;
        d[3*32 +: 32] = 32'h0033_0003;
        d[9*32 +: 32] = 32'h0099_0009;
        send_beat(d, 1'b1, 1'b1, 6'd0);
        wait_drain();

        // All-zero sop beat followed by an eop beat with lane 0 nonzero.
        send_beat('0, 1'b1, 1'b0, 6'd0);
        d = '0;
        d[31:0] = 32'h5555_AAAA;
        send_beat(d, 1'b0, 1'b1, 6'd0);
        wait_drain();

        // Reset in the middle of draining a beat.
        base = lanes_seen;
        d = '0;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'h7700_0000 + 32'(k);
        send_beat(d, 1'b1, 1'b1, 6'd0);
        t = 0;
        while (lanes_seen < base + 5 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        d = '0;
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'h0808_0000 + 32'(k + 1);
        send_beat(d, 1'b1, 1'b1, 6'd48);
        wait_drain();
        check("pkt_cnt_after_reset", pkt_cnt, 32'd1);

        // Randomized packets with random backpressure and gaps.
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                send_beat(rand_beat(), (b == 0), (b == nb - 1), 6'($urandom_range(0, 63)));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        wait_drain();
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(q.size()), 32'(0));
        check("final_pkt_cnt", pkt_cnt, exp_pkt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
